// File: rtl/gf2mz_add_sched_pkg.sv
// gf2mz_sched_pkg: shared FSM encoding and default sizes for the polynomial-add scheduler
package gf2mz_sched_pkg;
  localparam int BANK_W_DEF = 3;
  localparam int TMO_CYC_DEF = 1024;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;
endpackage

// File: rtl/gf2mz_add_sched_if.sv
// gf2mz_add_sched_if: requester, crossbar-select and adder-engine signals of the scheduler
interface gf2mz_add_sched_if #(
  parameter int NREQ = 4,
  parameter int BANK_W = 3
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*BANK_W-1:0] req_a_bank;
  logic [NREQ*BANK_W-1:0] req_b_bank;
  logic [NREQ*BANK_W-1:0] req_c_bank;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack;
  logic busy;
  logic [BANK_W-1:0] a_sel;
  logic [BANK_W-1:0] b_sel;
  logic [BANK_W-1:0] c_sel;
  logic eng_start;
  logic eng_rst_b;
  logic eng_done;
  logic err;
  logic [IW-1:0] err_id;
  modport master (
    output req, req_a_bank, req_b_bank, req_c_bank, eng_done,
    input grant, ack, busy, a_sel, b_sel, c_sel, eng_start, eng_rst_b, err, err_id
  );
  modport slave (
    input req, req_a_bank, req_b_bank, req_c_bank, eng_done,
    output grant, ack, busy, a_sel, b_sel, c_sel, eng_start, eng_rst_b, err, err_id
  );
endinterface

// File: rtl/gf2mz_rr_pick.sv
// gf2mz_rr_pick: round-robin winner search starting one past the last granted index
module gf2mz_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   win
);
  logic [IW:0] base, s;
  logic [NREQ-1:0] rot;
  logic [IW-1:0] off;
  always_comb begin
    base = {1'b0, ptr} + (IW+1)'(1);
    rot = NREQ'({req, req} >> base);
    off = '0;
    for (int o = NREQ - 1; o >= 0; o--) if (rot[o]) off = IW'(o);
    s = base + {1'b0, off};
    win = (s >= (IW+1)'(NREQ)) ? IW'(s - (IW+1)'(NREQ)) : IW'(s);
    valid = |req;
  end
endmodule

// File: rtl/gf2mz_add_sched.sv
// gf2mz_add_sched: round-robin sharing of one GF(2^m)[z] adder; watchdog abort enabled by GF2MZ_SCHED_WDOG_EN
module gf2mz_add_sched
  import gf2mz_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int BANK_W = BANK_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input logic clk,
  input logic rst,
  gf2mz_add_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  logic [IW-1:0] ptr, win, pick;
  logic pick_v;
  logic [NREQ-1:0] win_oh;
  logic [BANK_W-1:0] a_bank [NREQ];
  logic [BANK_W-1:0] b_bank [NREQ];
  logic [BANK_W-1:0] c_bank [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_bank
    assign a_bank[g] = bus.req_a_bank[g*BANK_W +: BANK_W];
    assign b_bank[g] = bus.req_b_bank[g*BANK_W +: BANK_W];
    assign c_bank[g] = bus.req_c_bank[g*BANK_W +: BANK_W];
  end
  assign win_oh = NREQ'(1) << win;
  gf2mz_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .valid(pick_v),
    .win(pick)
  );
`ifdef GF2MZ_SCHED_WDOG_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt;
`else
  assign bus.err = 1'b0;
  assign bus.err_id = '0;
`endif
  // Outputs are registered from the current state, so eng_start and ack trail GRANT and DONE by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(NREQ - 1);
      win <= '0;
      bus.grant <= '0;
      bus.ack <= '0;
      bus.busy <= 1'b0;
      bus.a_sel <= '0;
      bus.b_sel <= '0;
      bus.c_sel <= '0;
      bus.eng_start <= 1'b0;
      bus.eng_rst_b <= 1'b0;
`ifdef GF2MZ_SCHED_WDOG_EN
      bus.err <= 1'b0;
      bus.err_id <= '0;
      cnt <= '0;
`endif
    end else begin
      bus.ack <= '0;
      bus.eng_start <= (state == GRANT);
      bus.eng_rst_b <= 1'b1;
`ifdef GF2MZ_SCHED_WDOG_EN
      bus.err <= 1'b0;
`endif
      case (state)
        IDLE: if (pick_v) begin
          state <= GRANT;
          win <= pick;
          bus.grant <= NREQ'(1) << pick;
          bus.busy <= 1'b1;
          bus.a_sel <= a_bank[pick];
          bus.b_sel <= b_bank[pick];
          bus.c_sel <= c_bank[pick];
        end
        GRANT: begin
          state <= RUN;
`ifdef GF2MZ_SCHED_WDOG_EN
          cnt <= '0;
`endif
        end
`ifdef GF2MZ_SCHED_WDOG_EN
        RUN: if (bus.eng_done) state <= DONE;
        else if (cnt == CW'(TMO_CYC - 1)) begin
          state <= ABORT;
          bus.err <= 1'b1;
          bus.err_id <= win;
          bus.ack <= win_oh;
          bus.grant <= '0;
          bus.eng_rst_b <= 1'b0;
          ptr <= win;
        end else cnt <= cnt + CW'(1);
        ABORT: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
`else
        RUN: if (bus.eng_done) state <= DONE;
`endif
        DONE: begin
          state <= IDLE;
          bus.ack <= win_oh;
          bus.grant <= '0;
          bus.busy <= 1'b0;
          ptr <= win;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2mz_add_sched.sv
// tb_gf2mz_add_sched: randomized checks of round-robin order, select latching, handshake timing and reset
module tb_gf2mz_add_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int m_ptr = 3;
  logic [2:0] a_bk [4];
  logic [2:0] b_bk [4];
  logic [2:0] c_bk [4];

  gf2mz_add_sched_if #(.NREQ(4), .BANK_W(3)) bus ();
  gf2mz_add_sched #(.NREQ(4), .BANK_W(3), .TMO_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic int rr(input logic [3:0] r, input int p);
    for (int o = 1; o <= 4; o++) if (r[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_banks();
    for (int i = 0; i < 4; i++) begin
      bus.req_a_bank[i*3 +: 3] = a_bk[i];
      bus.req_b_bank[i*3 +: 3] = b_bk[i];
      bus.req_c_bank[i*3 +: 3] = c_bk[i];
    end
  endtask

  task automatic rand_bank(input int i);
    a_bk[i] = 3'($urandom_range(0, 7));
    b_bk[i] = 3'($urandom_range(0, 7));
    c_bk[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_grant(output bit ok);
    int n = 0;
    while (bus.grant === 4'b0 && n < 20) begin
      tick();
      n++;
    end
    ok = (bus.grant !== 4'b0);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL grant_timeout got=%b required nonzero", bus.grant);
    end
  endtask

  // One full transaction: engine answers lat cycles after the start pulse; clr/set update req at the ack
  task automatic serve(input int lat, input int exp, input logic [3:0] clr, input logic [3:0] set);
    int starts, bad;
    bit ok;
    logic [3:0] oh;
    oh = 4'b0001 << exp;
    wait_grant(ok);
    if (!ok) return;
    vectors++;
    if (bus.grant !== oh) begin
      miscompares++;
      $display("FAIL grant got=%b required=%b", bus.grant, oh);
    end
    vectors++;
    if ({bus.a_sel, bus.b_sel, bus.c_sel, bus.busy} !== {a_bk[exp], b_bk[exp], c_bk[exp], 1'b1}) begin
      miscompares++;
      $display("FAIL sel got=%0d/%0d/%0d busy=%b required=%0d/%0d/%0d busy=1",
               bus.a_sel, bus.b_sel, bus.c_sel, bus.busy, a_bk[exp], b_bk[exp], c_bk[exp]);
    end
    tick();
    vectors++;
    if (bus.eng_start !== 1'b1) begin
      miscompares++;
      $display("FAIL eng_start got=%b required=1", bus.eng_start);
    end
    starts = 0;
    bad = 0;
    for (int c = 1; c <= lat; c++) begin
      tick();
      starts += int'(bus.eng_start);
      if (bus.grant !== oh || bus.ack !== 4'b0 || bus.eng_rst_b !== 1'b1 || bus.err !== 1'b0 ||
          {bus.a_sel, bus.b_sel, bus.c_sel} !== {a_bk[exp], b_bk[exp], c_bk[exp]}) bad++;
    end
    vectors++;
    if (starts != 0 || bad != 0) begin
      miscompares++;
      $display("FAIL run_hold extra_starts=%0d bad_cycles=%0d required 0/0", starts, bad);
    end
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    vectors++;
    if (bus.ack !== 4'b0) begin
      miscompares++;
      $display("FAIL early_ack got=%b required=0000", bus.ack);
    end
    tick();
    vectors++;
    if (bus.ack !== oh || bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL ack got ack=%b grant=%b busy=%b err=%b required ack=%b grant=0000 busy=0 err=0",
               bus.ack, bus.grant, bus.busy, bus.err, oh);
    end
    bus.req = (bus.req & ~clr) | set;
    for (int i = 0; i < 4; i++) if (set[i]) rand_bank(i);
    apply_banks();
    tick();
    vectors++;
    if (bus.ack !== 4'b0) begin
      miscompares++;
      $display("FAIL ack_len got=%b required=0000", bus.ack);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({bus.grant, bus.ack, bus.busy, bus.eng_start, bus.eng_rst_b, bus.err, bus.err_id,
         bus.a_sel, bus.b_sel, bus.c_sel} !== 23'b0) begin
      miscompares++;
      $display("FAIL reset_state got grant=%b ack=%b busy=%b start=%b rst_b=%b err=%b required all 0",
               bus.grant, bus.ack, bus.busy, bus.eng_start, bus.eng_rst_b, bus.err);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.eng_rst_b !== 1'b0) begin
      miscompares++;
      $display("FAIL eng_rst_b_hold got=%b required=0", bus.eng_rst_b);
    end
    tick();
    vectors++;
    if (bus.eng_rst_b !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL eng_rst_b_rise got=%b busy=%b required 1/0", bus.eng_rst_b, bus.busy);
    end
  endtask

  task automatic test_single();
    int exp;
    a_bk[0] = 3'd1;
    b_bk[0] = 3'd2;
    c_bk[0] = 3'd3;
    apply_banks();
    bus.req = 4'b0001;
    exp = rr(bus.req, m_ptr);
    serve(20, exp, 4'b0001, 4'b0000);
    m_ptr = exp;
  endtask

  task automatic test_fairness();
    int exp;
    for (int i = 0; i < 4; i++) rand_bank(i);
    apply_banks();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = rr(4'b1111, m_ptr);
      serve(int'($urandom_range(1, 6)), exp, (k == 4) ? 4'b1111 : 4'b0000, 4'b0000);
      m_ptr = exp;
      if (k < 4) begin
        vectors++;
        if (bus.grant === 4'b0) begin
          miscompares++;
          $display("FAIL back_to_back got=%b required nonzero", bus.grant);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int exp;
    for (int i = 0; i < 4; i++) rand_bank(i);
    apply_banks();
    bus.req = 4'b0100;
    exp = rr(bus.req, m_ptr);
    serve(3, exp, 4'b0100, 4'b0000);
    m_ptr = exp;
    bus.req = 4'b0101;
    exp = rr(bus.req, m_ptr);
    serve(4, exp, 4'b0001, 4'b0000);
    m_ptr = exp;
    exp = rr(bus.req, m_ptr);
    serve(2, exp, 4'b0100, 4'b0000);
    m_ptr = exp;
  endtask

  task automatic test_reset_mid_run();
    int exp, bad;
    bit ok;
    bus.req = 4'b0100;
    wait_grant(ok);
    if (ok) tick();
    vectors++;
    if (bus.eng_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_run_start got=%b required=1", bus.eng_start);
    end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.grant, bus.ack, bus.busy, bus.eng_start, bus.eng_rst_b, bus.err, bus.err_id,
         bus.a_sel, bus.b_sel, bus.c_sel} !== 23'b0) begin
      miscompares++;
      $display("FAIL rst_async got grant=%b ack=%b busy=%b rst_b=%b required all 0",
               bus.grant, bus.ack, bus.busy, bus.eng_rst_b);
    end
    bus.req = 4'b0000;
    bad = 0;
    repeat (3) begin
      tick();
      if (bus.ack !== 4'b0 || bus.eng_rst_b !== 1'b0) bad++;
    end
    rst = 1'b0;
    tick();
    if (bus.ack !== 4'b0 || bus.eng_rst_b !== 1'b1 || bus.busy !== 1'b0) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_recover bad_cycles=%0d required=0", bad);
    end
    m_ptr = 3;
    rand_bank(1);
    apply_banks();
    bus.req = 4'b0010;
    exp = rr(bus.req, m_ptr);
    serve(7, exp, 4'b0010, 4'b0000);
    m_ptr = exp;
  endtask

  task automatic test_random();
    logic [3:0] pend, nset;
    int exp;
    for (int i = 0; i < 4; i++) rand_bank(i);
    apply_banks();
    pend = 4'($urandom_range(1, 15));
    bus.req = pend;
    for (int it = 0; it < 25; it++) begin
      exp = rr(pend, m_ptr);
      pend[exp] = 1'b0;
      nset = (it == 24) ? 4'b0 : (4'($urandom) & ~pend);
      if (it != 24 && (pend | nset) == 4'b0) nset = 4'b0001 << $urandom_range(0, 3);
      serve(int'($urandom_range(1, 12)), exp, 4'b0001 << exp, nset);
      pend = pend | nset;
      m_ptr = exp;
    end
  endtask

`ifdef GF2MZ_SCHED_WDOG_EN
  task automatic test_watchdog();
    int exp;
    bit ok;
    logic [3:0] oh;
    rand_bank(0);
    apply_banks();
    bus.req = 4'b0001;
    exp = rr(bus.req, m_ptr);
    oh = 4'b0001 << exp;
    wait_grant(ok);
    if (ok) tick();
    repeat (15) tick();
    vectors++;
    if (bus.err !== 1'b0 || bus.ack !== 4'b0 || bus.grant !== oh) begin
      miscompares++;
      $display("FAIL wdog_early got err=%b ack=%b grant=%b required 0/0000/%b", bus.err, bus.ack, bus.grant, oh);
    end
    tick();
    vectors++;
    if (bus.err !== 1'b1 || bus.err_id !== 2'(exp) || bus.ack !== oh || bus.eng_rst_b !== 1'b0 ||
        bus.grant !== 4'b0) begin
      miscompares++;
      $display("FAIL wdog_abort got err=%b id=%0d ack=%b rst_b=%b grant=%b required 1/%0d/%b/0/0000",
               bus.err, bus.err_id, bus.ack, bus.eng_rst_b, bus.grant, exp, oh);
    end
    bus.req = 4'b0000;
    tick();
    vectors++;
    if (bus.err !== 1'b0 || bus.eng_rst_b !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 4'b0 ||
        bus.err_id !== 2'(exp)) begin
      miscompares++;
      $display("FAIL wdog_exit got err=%b rst_b=%b busy=%b id=%0d required 0/1/0/%0d",
               bus.err, bus.eng_rst_b, bus.busy, bus.err_id, exp);
    end
    m_ptr = exp;
  endtask

  task automatic test_watchdog_edge();
    int exp, prev;
    prev = m_ptr;
    rand_bank(1);
    apply_banks();
    bus.req = 4'b0010;
    exp = rr(bus.req, m_ptr);
    serve(15, exp, 4'b0010, 4'b0000);
    m_ptr = exp;
    vectors++;
    if (bus.err_id !== 2'(prev)) begin
      miscompares++;
      $display("FAIL wdog_edge_id got=%0d required=%0d", bus.err_id, prev);
    end
  endtask
`endif

  initial begin
    bus.req = 4'b0;
    bus.eng_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_bk[i] = 3'd0;
      b_bk[i] = 3'd0;
      c_bk[i] = 3'd0;
    end
    apply_banks();
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_reset_mid_run();
    test_random();
`ifdef GF2MZ_SCHED_WDOG_EN
    test_watchdog();
    test_watchdog_edge();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
